// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single req/gnt/rvalid memory port.
// Response routing uses an in-order FIFO of granted master IDs.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                port_req_o,
  input  logic                port_gnt_i,
  input  logic                port_rvalid_i,
  output logic [ADDR_W-1:0]   port_addr_o,
  output logic                port_we_o,
  output logic [DATA_W/8-1:0] port_be_o,
  output logic [DATA_W-1:0]   port_wdata_o,
  input  logic [DATA_W-1:0]   port_rdata_i,
  output logic                unexp_rvalid_o,
  output logic [31:0]         m0_grant_cnt_o,
  output logic [31:0]         m1_grant_cnt_o
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(MAX_OUTST);

  // Handshake: a transfer moves when port_req_o && port_gnt_i in the same cycle;
  // a response is consumed whenever port_rvalid_i is high (no back-pressure).
  logic             rr_q;
  logic             lock_q;
  logic             lock_id_q;
  logic             id_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] occ_q;
  logic             unexp_q;
  logic [31:0]      cnt0_q;
  logic [31:0]      cnt1_q;

  logic winner;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;
  logic head_id;

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);

  // A stalled master keeps the port until granted, as long as it still requests.
  always_comb begin
    winner = 1'b0;
    if (lock_q && (lock_id_q ? m1_req_i : m0_req_i)) begin
      winner = lock_id_q;
    end else if (m0_req_i && m1_req_i) begin
      winner = rr_q;
    end else if (m1_req_i) begin
      winner = 1'b1;
    end
  end

  assign port_req_o   = (m0_req_i | m1_req_i) & ~fifo_full & ~rst_i;
  assign accept       = port_req_o & port_gnt_i;
  assign port_addr_o  = winner ? m1_addr_i  : m0_addr_i;
  assign port_we_o    = winner ? m1_we_i    : m0_we_i;
  assign port_be_o    = winner ? m1_be_i    : m0_be_i;
  assign port_wdata_o = winner ? m1_wdata_i : m0_wdata_i;
  assign m0_gnt_o     = accept & ~winner;
  assign m1_gnt_o     = accept & winner;

  assign head_id     = id_mem[rd_ptr_q];
  assign pop         = port_rvalid_i & ~fifo_empty & ~rst_i;
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop & head_id;
  assign m0_rdata_o  = port_rdata_i;
  assign m1_rdata_o  = port_rdata_i;
  assign m0_err_o    = 1'b0;
  assign m1_err_o    = 1'b0;

  assign unexp_rvalid_o = unexp_q;
  assign m0_grant_cnt_o = cnt0_q;
  assign m1_grant_cnt_o = cnt1_q;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_mem[wr_ptr_q] <= winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      unexp_q   <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        rr_q     <= ~winner;
        lock_q   <= 1'b0;
        if (!winner && cnt0_q != 32'hFFFF_FFFF) cnt0_q <= cnt0_q + 32'd1;
        if (winner && cnt1_q != 32'hFFFF_FFFF)  cnt1_q <= cnt1_q + 32'd1;
      end else if (port_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= winner;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
      if (port_rvalid_i && fifo_empty) begin
        unexp_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed vector table, directed multi-cycle sequences,
// and random traffic checked against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [ADDR_W-1:0] m0_addr, m1_addr, port_addr;
  logic              m0_we, m1_we, port_we;
  logic [BE_W-1:0]   m0_be, m1_be, port_be;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, port_wdata;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, port_rdata;
  logic              m0_err, m1_err;
  logic              port_req, port_gnt, port_rvalid, unexp_rvalid;
  logic [31:0]       m0_cnt, m1_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .port_req_o(port_req), .port_gnt_i(port_gnt), .port_rvalid_i(port_rvalid),
    .port_addr_o(port_addr), .port_we_o(port_we), .port_be_o(port_be),
    .port_wdata_o(port_wdata), .port_rdata_i(port_rdata),
    .unexp_rvalid_o(unexp_rvalid), .m0_grant_cnt_o(m0_cnt), .m1_grant_cnt_o(m1_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: arbitration rules plus an in-order queue of granted IDs.
  logic        m_rr, m_lock, m_lock_id, m_unexp;
  logic        exp_q[$];
  logic [31:0] m_cnt0, m_cnt1;
  logic        e_win, e_req, e_acc, e_pop, e_head;

  typedef struct packed {
    logic r0, r1, g, rv;
    logic g0, g1, v0, v1;
    logic req, win;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic rand_payload();
    m0_addr    = $urandom;
    m1_addr    = ~m0_addr;
    m0_we      = 1'($urandom_range(0, 1));
    m1_we      = ~m0_we;
    m0_be      = BE_W'($urandom);
    m1_be      = ~m0_be;
    m0_wdata   = $urandom;
    m1_wdata   = $urandom;
    port_rdata = $urandom;
  endtask

  task automatic begin_cycle(input logic r0, input logic r1, input logic g, input logic rv);
    m0_req      = r0;
    m1_req      = r1;
    port_gnt    = g;
    port_rvalid = rv;
    #4;
  endtask

  task automatic model_check();
    if (m_lock && (m_lock_id ? m1_req : m0_req)) e_win = m_lock_id;
    else if (m0_req && m1_req)                   e_win = m_rr;
    else                                         e_win = m1_req;
    e_req  = (m0_req || m1_req) && (exp_q.size() < MAX_OUTST) && !rst;
    e_acc  = e_req && port_gnt;
    e_pop  = port_rvalid && (exp_q.size() > 0) && !rst;
    e_head = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    chk("port_req", port_req, e_req);
    chk("m0_gnt", m0_gnt, e_acc && !e_win);
    chk("m1_gnt", m1_gnt, e_acc && e_win);
    chk("m0_rvalid", m0_rvalid, e_pop && !e_head);
    chk("m1_rvalid", m1_rvalid, e_pop && e_head);
    chk("m0_rdata", m0_rdata, port_rdata);
    chk("m1_rdata", m1_rdata, port_rdata);
    chk("err", {m0_err, m1_err}, 2'b00);
    if (!rst) begin
      chk("port_addr", port_addr, e_win ? m1_addr : m0_addr);
      chk("port_we", port_we, e_win ? m1_we : m0_we);
      chk("port_be", port_be, e_win ? m1_be : m0_be);
      chk("port_wdata", port_wdata, e_win ? m1_wdata : m0_wdata);
      chk("m0_cnt", m0_cnt, m_cnt0);
      chk("m1_cnt", m1_cnt, m_cnt1);
      chk("unexp", unexp_rvalid, m_unexp);
    end
  endtask

  task automatic end_cycle();
    if (rst) begin
      m_rr = 0; m_lock = 0; m_lock_id = 0; m_unexp = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end else begin
      if (port_rvalid && exp_q.size() == 0) m_unexp = 1;
      if (e_pop) void'(exp_q.pop_front());
      if (e_acc) begin
        exp_q.push_back(e_win);
        m_rr   = ~e_win;
        m_lock = 0;
        if (!e_win && m_cnt0 != 32'hFFFF_FFFF) m_cnt0++;
        if (e_win && m_cnt1 != 32'hFFFF_FFFF)  m_cnt1++;
      end else if (e_req) begin
        m_lock    = 1;
        m_lock_id = e_win;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_payload();
      begin_cycle(1, 1, 1, 1);
      model_check();
      chk("rst_outputs", {port_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 5'b0);
      end_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic step(input logic r0, input logic r1, input logic g, input logic rv);
    begin_cycle(r0, r1, g, rv);
    model_check();
    end_cycle();
  endtask

  initial begin
    rst = 1'b1;
    rand_payload();
    begin_cycle(0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: nothing outstanding, counters clear
    rand_payload();
    begin_cycle(0, 0, 0, 0);
    model_check();
    chk("reset_cnt0", m0_cnt, 32'd0);
    chk("reset_cnt1", m1_cnt, 32'd0);
    chk("reset_unexp", unexp_rvalid, 1'b0);
    end_cycle();

    // Single master read with one-cycle response
    rand_payload();
    m0_addr = 32'h0000_0100;
    m0_we   = 1'b0;
    begin_cycle(1, 0, 1, 0);
    model_check();
    chk("single_gnt0", m0_gnt, 1'b1);
    chk("single_addr", port_addr, 32'h100);
    end_cycle();
    begin_cycle(0, 0, 0, 1);
    model_check();
    chk("single_rv0", m0_rvalid, 1'b1);
    chk("single_rv1", m1_rvalid, 1'b0);
    end_cycle();
    begin_cycle(0, 0, 0, 0);
    model_check();
    chk("single_cnt0", m0_cnt, 32'd1);
    end_cycle();

    // Responses return in grant order
    do_reset();
    rand_payload();
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    port_rdata = 32'h0000_AAAA;
    begin_cycle(0, 0, 0, 1);
    model_check();
    chk("order_rv0", {m0_rvalid, m1_rvalid}, 2'b10);
    chk("order_data0", m0_rdata, 32'h0000_AAAA);
    end_cycle();
    port_rdata = 32'h0000_BBBB;
    begin_cycle(0, 0, 0, 1);
    model_check();
    chk("order_rv1", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("order_data1", m1_rdata, 32'h0000_BBBB);
    end_cycle();

    // Table: contention, lock under stall, FIFO full and drain
    tbl[0]  = 10'b1110_1000_10;
    tbl[1]  = 10'b1111_0110_11;
    tbl[2]  = 10'b1111_1001_10;
    tbl[3]  = 10'b1111_0110_11;
    tbl[4]  = 10'b1111_1001_10;
    tbl[5]  = 10'b1111_0110_11;
    tbl[6]  = 10'b0001_0001_00;
    tbl[7]  = 10'b1010_1000_10;
    tbl[8]  = 10'b1000_0000_10;
    tbl[9]  = 10'b1100_0000_10;
    tbl[10] = 10'b1100_0000_10;
    tbl[11] = 10'b1111_1010_10;
    tbl[12] = 10'b1110_0100_11;
    tbl[13] = 10'b1110_0000_00;
    tbl[14] = 10'b1111_0010_00;
    tbl[15] = 10'b1110_1000_10;
    tbl[16] = 10'b0001_0001_00;
    tbl[17] = 10'b0001_0010_00;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rand_payload();
      begin_cycle(tbl[i].r0, tbl[i].r1, tbl[i].g, tbl[i].rv);
      model_check();
      chk($sformatf("tbl%0d_req", i), port_req, tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i), {m0_gnt, m1_gnt}, {tbl[i].g0, tbl[i].g1});
      chk($sformatf("tbl%0d_rv", i), {m0_rvalid, m1_rvalid}, {tbl[i].v0, tbl[i].v1});
      chk($sformatf("tbl%0d_addr", i), port_addr, tbl[i].win ? m1_addr : m0_addr);
      end_cycle();
    end
    begin_cycle(0, 0, 0, 0);
    chk("tbl_cnt0", m0_cnt, 32'd6);
    chk("tbl_cnt1", m1_cnt, 32'd4);
    chk("tbl_unexp", unexp_rvalid, 1'b0);
    model_check();
    end_cycle();

    // Unexpected response, then reset with one transfer outstanding
    begin_cycle(0, 0, 0, 1);
    model_check();
    chk("unexp_norv", {m0_rvalid, m1_rvalid}, 2'b00);
    end_cycle();
    begin_cycle(1, 0, 1, 0);
    model_check();
    chk("unexp_set", unexp_rvalid, 1'b1);
    end_cycle();
    do_reset();
    begin_cycle(0, 0, 0, 0);
    model_check();
    chk("rst_cnt0", m0_cnt, 32'd0);
    chk("rst_unexp", unexp_rvalid, 1'b0);
    end_cycle();
    begin_cycle(0, 0, 0, 1);
    model_check();
    chk("rst_discard", {m0_rvalid, m1_rvalid}, 2'b00);
    end_cycle();
    begin_cycle(0, 0, 0, 0);
    model_check();
    chk("rst_unexp_again", unexp_rvalid, 1'b1);
    end_cycle();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_payload();
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
